// File: rtl/lif_pkg.sv
// Types and constants shared between the LIF sharing scheduler and the LIF layer it feeds.
package lif_pkg;
  localparam int T_STEPS_DEF     = 4;
  localparam int COUNT_WIDTH_DEF = 4;
  localparam int ID_W_MAX        = 3;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Entry width is fixed at the widest ID so the type is independent of N_REQ.
  typedef struct packed {
    logic [ID_W_MAX-1:0]        id;
    logic [COUNT_WIDTH_DEF-1:0] spike;
  } rsp_entry_t;
endpackage

// File: rtl/lif_share_sched_if.sv
// Request, LIF-pipeline and response signals of the shared LIF scheduler.
interface lif_share_sched_if import lif_pkg::*; #(
  parameter int N_REQ       = 4,
  parameter int IN_WIDTH    = 18,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int ID_W        = id_width(N_REQ)
);
  logic [N_REQ-1:0][IN_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]               req_valid;
  logic [N_REQ-1:0]               req_ready;
  logic [IN_WIDTH-1:0]            lif_din;
  logic                           lif_din_valid;
  logic                           lif_dout_ready;
  logic [COUNT_WIDTH-1:0]         lif_spike;
  logic                           lif_dout_valid;
  logic [ID_W-1:0]                rsp_id;
  logic [COUNT_WIDTH-1:0]         rsp_spike;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic                           tag_err;
  logic                           busy;

  modport slave (
    input  req_data, req_valid, lif_spike, lif_dout_valid, rsp_ready,
    output req_ready, lif_din, lif_din_valid, lif_dout_ready,
           rsp_id, rsp_spike, rsp_valid, tag_err, busy
  );

  modport master (
    output req_data, req_valid, lif_spike, lif_dout_valid, rsp_ready,
    input  req_ready, lif_din, lif_din_valid, lif_dout_ready,
           rsp_id, rsp_spike, rsp_valid, tag_err, busy
  );
endinterface

// File: rtl/lif_rsp_fifo.sv
// Synchronous response FIFO; head entry reads as zero while empty.
module lif_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/lif_share_sched.sv
// Round-robin sharing of one non-stallable LIF pipeline among N_REQ requesters,
// with ID tags riding alongside and credit-limited issue into a response FIFO.
module lif_share_sched import lif_pkg::*; #(
  parameter int N_REQ       = 4,
  parameter int IN_WIDTH    = 18,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int T_STEPS     = T_STEPS_DEF,
  parameter int OBUF_DEPTH  = 8,
  parameter int ID_W        = id_width(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  lif_share_sched_if.slave  bus
);
  localparam int CW = $clog2(OBUF_DEPTH);

  logic [ID_W-1:0]              rr_ptr, gnt_id;
  logic [CW:0]                  inflight, fifo_count;
  logic [T_STEPS-1:0]           vld_pipe;
  logic [T_STEPS-1:0][ID_W-1:0] id_pipe;
  logic                         issue, issue_ok, exit_vld, push, tag_err_q;
  logic                         fifo_full, fifo_empty;
  rsp_entry_t                   push_entry, head_entry;

  // Credit uses registered state only; a pop frees a slot one cycle later.
  assign issue_ok = rst_n &&
    (({1'b0, inflight} + {1'b0, fifo_count}) < (CW+2)'(OBUF_DEPTH));

  // Walk downward so the last hit is the nearest valid requester from rr_ptr.
  always_comb begin
    int idx;
    idx    = 0;
    issue  = 1'b0;
    gnt_id = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (issue_ok && bus.req_valid[idx]) begin
        issue  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.lif_din   = '0;
    if (issue) begin
      bus.req_ready[gnt_id] = 1'b1;
      bus.lif_din           = bus.req_data[gnt_id];
    end
  end

  assign bus.lif_din_valid  = issue;
  assign bus.lif_dout_ready = 1'b1;

  assign exit_vld = vld_pipe[T_STEPS-1];
  assign push     = bus.lif_dout_valid && exit_vld && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      inflight  <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      if (issue) rr_ptr <= (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + 1'b1;
      vld_pipe[0] <= issue;
      id_pipe[0]  <= gnt_id;
      for (int i = 1; i < T_STEPS; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
      inflight <= inflight + (CW+1)'(issue) - (CW+1)'(exit_vld);
      if (bus.lif_dout_valid != exit_vld) tag_err_q <= 1'b1;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.id    = ID_W_MAX'(id_pipe[T_STEPS-1]);
    push_entry.spike = bus.lif_spike;
  end

  lif_rsp_fifo #(.DEPTH(OBUF_DEPTH), .WIDTH($bits(rsp_entry_t))) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (bus.rsp_ready),
    .dout  (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_id    = ID_W'(head_entry.id);
  assign bus.rsp_spike = head_entry.spike;
  assign bus.tag_err   = tag_err_q;
  assign bus.busy      = (inflight != '0) || !fifo_empty;
endmodule

// File: doc/lif_share_sched.md
Name: lif_share_sched

Overview:
- Shares one fixed-latency LIF pipeline (T_STEPS-stage, input-gated, non-stallable) among N_REQ requesters.
- Round-robin arbitrates one input current per cycle into the pipeline and carries a requester-ID tag alongside each item.
- Buffers the spike counts returned by the pipeline in a response FIFO and returns each as {id, spike_count} under valid/ready.
- Credit-limits issue so the FIFO cannot overflow, because the pipeline itself cannot be back-pressured.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IN_WIDTH, 18, signed input current width.
- COUNT_WIDTH, 4, spike count width.
- T_STEPS, 4, pipeline latency in cycles; must match the shared LIF layer.
- OBUF_DEPTH, 8, response FIFO depth; must be >= T_STEPS, power of 2.
- ID_W, clog2(N_REQ), requester ID width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset; all state clears immediately.
- req_data  in  N_REQ*IN_WIDTH  per-requester current; slice i = requester i.
- req_valid  in  N_REQ  request valid.
- req_ready  out  N_REQ  one-hot grant; handshake when valid&ready.
- lif_din  out  IN_WIDTH  current to the LIF pipeline.
- lif_din_valid  out  1  issue strobe.
- lif_dout_ready  out  1  tied to 1; the pipeline is never stalled.
- lif_spike  in  COUNT_WIDTH  spike count from the pipeline.
- lif_dout_valid  in  1  pipeline output valid.
- rsp_id  out  ID_W  requester ID of the head entry.
- rsp_spike  out  COUNT_WIDTH  spike count of the head entry.
- rsp_valid  out  1  FIFO non-empty.
- rsp_ready  in  1  consumer accept.
- tag_err  out  1  sticky: lif_dout_valid disagreed with the tag pipe.
- busy  out  1  inflight != 0 or FIFO non-empty.

Behaviour:
- Reset values: req_ready=0, lif_din_valid=0, lif_din=0, rsp_valid=0, rsp_id=0, rsp_spike=0, tag_err=0, busy=0.
- Reset clears rr_ptr=0, inflight=0, FIFO pointers, and the tag pipe.
- Reset mid-operation discards all in-flight and buffered items; the LIF pipeline shares rst_n.
- Credit rule: issue_ok = (inflight + fifo_count) < OBUF_DEPTH, computed from registered values only. No same-cycle credit from a pop.
- Arbitration (combinational): if issue_ok, grant the first requester with req_valid, searching from rr_ptr upward with wrap.
  - req_ready = grant one-hot; otherwise all zero.
  - A requester never sees ready without issue_ok.
- Issue cycle: lif_din = granted slice, lif_din_valid = 1 (combinational, same cycle as the handshake).
  - rr_ptr <= granted index + 1 mod N_REQ.
  - rr_ptr is unchanged when nothing is granted.
- Tag pipe: T_STEPS-deep shift register of {valid, id}, advancing every cycle. Stage 0 is loaded with {issue, granted id}.
- Retire: when lif_dout_valid=1, push {tag_pipe[T_STEPS-1].id, lif_spike} into the FIFO.
  - If lif_dout_valid != tag_pipe[T_STEPS-1].valid, set tag_err (sticky until reset).
  - A spurious retire is dropped.
  - A missing retire decrements inflight on the tag valid.
- inflight counter: +1 on issue, -1 on tag-pipe exit. Simultaneous issue and exit leaves it unchanged. Width clog2(OBUF_DEPTH)+1.
- Response FIFO (lif_rsp_fifo):
  - Registered outputs; rsp_valid rises the cycle after the first push.
  - Pop on rsp_valid&rsp_ready.
  - Simultaneous push and pop when full is impossible by the credit rule; when empty, push wins and no pop occurs.
  - Pointers wrap modulo OBUF_DEPTH.
- Latency: request handshake at cycle t gives rsp_valid at cycle t+T_STEPS+1 (empty FIFO).
- Ordering: responses appear in issue order.
- Throughput: 1 item/cycle sustained while rsp_ready=1.
- Full: with rsp_ready=0, exactly OBUF_DEPTH items are accepted, then req_ready stays 0.
  - Issue resumes the cycle after a pop lowers fifo_count.

Decomposition:
- Package lif_pkg holds:
  - ID_W derivation via clog2;
  - the rsp_entry_t struct {id, spike};
  - default T_STEPS/COUNT_WIDTH constants shared with the LIF layer, so latency cannot diverge.
- Sub-module lif_rsp_fifo: synchronous FIFO, parameterised on depth and width, with outputs count, full, and empty.

Test Plan:
- Single request: req_valid[2]=1, data=2000 at cycle 10 -> req_ready[2]=1 and lif_din_valid=1 at cycle 10; rsp_valid at cycle 15 (T_STEPS=4) with rsp_id=2 and spike equal to the LIF model; busy=0 after pop.
- Fairness: all four req_valid held for 12 cycles with rsp_ready=1 -> grant order 0,1,2,3 repeating; rsp_id order identical; zero idle cycles.
- Backpressure: rsp_ready=0 with all requesters valid -> exactly 8 handshakes, then req_ready=0 indefinitely. Raise rsp_ready -> 8 in-order responses, and the first new issue occurs the cycle after the first pop.
- Sparse priority: only req 1 and req 3 valid, rr_ptr=2 -> 3 granted, then 1, then 3; rr_ptr skips idle requesters.
- Reset mid-flight: assert rst_n=0 with 3 items in flight and 2 buffered -> all outputs are at reset values at once; after release, no stale responses appear and tag_err=0.
- Tag error: inject lif_dout_valid=1 with an empty tag pipe -> tag_err=1 sticky; FIFO count is unchanged.
